// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: multi-cycle instruction fetch stage.
// Owns the architectural PC, keeps at most one instruction-memory request
// outstanding, and hands each fetched word to the decoder over valid/ready.
// A redirect from execute replaces the PC. A fetch already in flight is
// allowed to complete, and its response is dropped.
module ifu_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active-low

  // PC redirect from execute (jal/jalr, taken branch, ecall, mret)
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  // instruction memory request channel
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,

  // instruction memory response channel
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,

  // decoder-facing output
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err
);

  // REQ : presenting a fetch request
  // WAIT: request accepted, waiting for its response
  // HOLD: instruction registered and offered to the decoder
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] pc;        // architectural PC of the next instruction
  logic [ADDR_W-1:0] req_addr;  // address of the request being presented / awaited
  logic              drop;      // the response in flight is stale; discard it

  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              req_fire;
  logic              rsp_fire;

  // Fetches are always word aligned, so the low target bits are ignored.
  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  // Sequential PC wraps modulo 2^ADDR_W.
  assign pc_inc       = pc + ADDR_W'(4);

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & imem_rsp_ready;

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  // State register with asynchronous reset back to the request state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values, independent of block evaluation order.
    if (!rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM next-state logic
  // ------------------------------------------------------------------
  // Next state from the current handshakes and redirects.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch
    // is inferred.
    state_nxt = state;
    unique case (state)
      ST_REQ: begin
        // A redirect here does not cancel the request. The request still
        // completes and its response is dropped in WAIT.
        if (req_fire) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp_fire) begin
          // Stale or redirected responses restart fetch; good ones are held.
          if (drop || redirect_valid) begin
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Either consumed by the decoder or flushed by a redirect.
        if (out_ready || redirect_valid) begin
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_REQ;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM outputs
  // ------------------------------------------------------------------
  // Handshake strobes decoded from the state. The request valid is also
  // gated by reset, so it is low while reset is asserted.
  always_comb begin
    imem_req_valid = rst && (state == ST_REQ);
    imem_rsp_ready = (state == ST_WAIT);
    out_valid      = (state == ST_HOLD);
  end

  assign imem_req_addr = req_addr;

  // ------------------------------------------------------------------
  // PC, request address and drop flag
  // ------------------------------------------------------------------
  // Update PC, request address and drop flag by state and redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      unique case (state)
        ST_REQ: begin
          // req_addr stays put until the handshake. The redirect only
          // retargets pc and marks the in-flight fetch as stale.
          if (redirect_valid) begin
            pc   <= redirect_tgt;
            drop <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (rsp_fire) begin
            if (redirect_valid) begin
              // A response that arrives with a redirect is discarded.
              // Fetch resumes at the target and no drop is left pending.
              pc       <= redirect_tgt;
              req_addr <= redirect_tgt;
              drop     <= 1'b0;
            end else if (drop) begin
              // Stale response: refetch from the redirected PC.
              req_addr <= pc;
              drop     <= 1'b0;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_tgt;
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            // Flush, or redirect after consumption. Both continue at the
            // target, never at pc+4.
            pc       <= redirect_tgt;
            req_addr <= redirect_tgt;
          end else if (out_ready) begin
            pc       <= pc_inc;
            req_addr <= pc_inc;
          end
        end
        default: begin
          drop <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output instruction register
  // ------------------------------------------------------------------
  // Capture a good response. The value holds stable through the whole
  // HOLD state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: these data registers are reset too, because the decoder-facing
    // outputs must read as zero in reset, not as leftover X.
    if (!rst) begin
      out_inst <= '0;
      out_pc   <= '0;
      out_err  <= 1'b0;
    end else if (state == ST_WAIT && rsp_fire && !drop && !redirect_valid) begin
      out_inst <= imem_rsp_data;
      out_pc   <= req_addr;
      out_err  <= imem_rsp_err;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench for the fetch controller.
// The instruction memory model returns the fetch address as the data word,
// after a programmable latency. Request and delivery logs are compared
// against hand-computed addresses.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;

  int n_total = 0;
  int n_pass  = 0;

  // memory model controls (driven from the initial block)
  int          mem_lat;
  logic [31:0] err_addr;

  // monitor state (written only by the posedge monitor)
  int          cyc = 0;
  int          req_hs_cnt = 0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] req_q[$];
  logic [31:0] opc_q[$];
  logic [31:0] oinst_q[$];
  logic        oerr_q[$];
  int          ocyc_q[$];

  // memory model state (written only by the negedge responder)
  int          served = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          pcnt = 0;

  ifu_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  // Record request and delivery handshakes as the DUT sees them.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst === 1'b1) begin
      if (imem_req_valid && imem_req_ready) begin
        req_hs_cnt    = req_hs_cnt + 1;
        last_req_addr = imem_req_addr;
        req_q.push_back(imem_req_addr);
      end
      if (out_valid && out_ready) begin
        opc_q.push_back(out_pc);
        oinst_q.push_back(out_inst);
        oerr_q.push_back(out_err);
        ocyc_q.push_back(cyc);
      end
    end
  end

  // Memory responder: answers each accepted request once, data = address.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      imem_rsp_valid = 1'b0;
      pend           = 1'b0;
      served         = req_hs_cnt;
    end else begin
      imem_rsp_valid = 1'b0;
      if (req_hs_cnt != served) begin
        served = req_hs_cnt;
        pend   = 1'b1;
        paddr  = last_req_addr;
        pcnt   = mem_lat;
      end
      if (pend) begin
        if (pcnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = paddr;
          imem_rsp_err   = (paddr == err_addr);
          pend           = 1'b0;
        end else begin
          pcnt = pcnt - 1;
        end
      end
    end
  end

  task automatic do_reset(input logic req_rdy, input logic o_rdy, input int lat);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = req_rdy;
    out_ready      = o_rdy;
    mem_lat        = lat;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_outs(input int n, input string name);
    for (int i = 0; i < 200 && opc_q.size() < n; i++) @(negedge clk);
    n_total++;
    if (opc_q.size() < n) $display("FAIL %s timeout: deliveries %0d required %0d", name, opc_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b1; mem_lat = 0;
    imem_rsp_data = '0; imem_rsp_err = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== RST_PC) $display("FAIL reset_req_addr got %h exp %h", imem_req_addr, RST_PC); else n_pass++;
    n_total++; if (imem_rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready got %b exp 0", imem_rsp_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if ({out_inst, out_pc, out_err} !== 65'd0) $display("FAIL reset_out_regs got %h/%h/%b exp 0", out_inst, out_pc, out_err); else n_pass++;
  endtask

  task automatic test_stream();
    int b;
    do_reset(1'b1, 1'b1, 0);
    b = opc_q.size();
    wait_outs(b + 3, "stream_wait");
    if (opc_q.size() >= b + 3) begin
      for (int i = 0; i < 3; i++) begin
        n_total++; if (opc_q[b+i] !== RST_PC + 32'(4*i)) $display("FAIL stream_pc%0d got %h exp %h", i, opc_q[b+i], RST_PC + 32'(4*i)); else n_pass++;
        n_total++; if (oinst_q[b+i] !== RST_PC + 32'(4*i)) $display("FAIL stream_inst%0d got %h exp %h", i, oinst_q[b+i], RST_PC + 32'(4*i)); else n_pass++;
      end
      for (int i = 1; i < 3; i++) begin
        n_total++; if (ocyc_q[b+i] - ocyc_q[b+i-1] !== 3) $display("FAIL stream_interval%0d got %0d exp 3", i, ocyc_q[b+i] - ocyc_q[b+i-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int b, rb;
    do_reset(1'b0, 1'b0, 0);
    b  = opc_q.size();
    rb = req_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) $display("FAIL stall_req%0d got %b/%h exp 1/%h", i, imem_req_valid, imem_req_addr, RST_PC);
      else n_pass++;
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    n_total++; if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b1) $display("FAIL stall_wait got req_valid %b rsp_ready %b exp 0/1", imem_req_valid, imem_rsp_ready); else n_pass++;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== RST_PC) $display("FAIL bp_hold%0d got %b/%h/%h exp 1/%h/%h", i, out_valid, out_pc, out_inst, RST_PC, RST_PC);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (opc_q.size() - b !== 1) $display("FAIL bp_out_count got %0d exp 1", opc_q.size() - b); else n_pass++;
    n_total++; if (req_q.size() - rb !== 1) $display("FAIL bp_req_count got %0d exp 1", req_q.size() - rb); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int b, rb;
    do_reset(1'b1, 1'b1, 2);
    b  = opc_q.size();
    rb = req_q.size();
    for (int i = 0; i < 50 && !(imem_rsp_ready === 1'b1 && last_req_addr === RST_PC + 32'h4); i++) @(negedge clk);
    n_total++; if (last_req_addr !== RST_PC + 32'h4) $display("FAIL rw_reach_wait got %h exp %h", last_req_addr, RST_PC + 32'h4); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;  // low bits must be ignored
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_outs(b + 2, "rw_wait");
    if (opc_q.size() >= b + 2) begin
      n_total++; if (opc_q[b] !== RST_PC) $display("FAIL rw_first got %h exp %h", opc_q[b], RST_PC); else n_pass++;
      n_total++; if (opc_q[b+1] !== 32'h8000_0100 || oinst_q[b+1] !== 32'h8000_0100) $display("FAIL rw_target got %h/%h exp 80000100", opc_q[b+1], oinst_q[b+1]); else n_pass++;
    end
    if (req_q.size() >= rb + 3) begin
      n_total++; if (req_q[rb+2] !== 32'h8000_0100) $display("FAIL rw_next_req got %h exp 80000100", req_q[rb+2]); else n_pass++;
    end
  endtask

  task automatic test_redirect_hold_ready();
    int b, rb, n8;
    do_reset(1'b1, 1'b1, 0);
    b  = opc_q.size();
    rb = req_q.size();
    for (int i = 0; i < 50 && !(out_valid === 1'b1 && out_pc === RST_PC + 32'h8); i++) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_outs(b + 4, "rh_wait");
    if (opc_q.size() >= b + 4) begin
      n8 = 0;
      for (int i = b; i < opc_q.size(); i++) if (opc_q[i] === RST_PC + 32'h8) n8++;
      n_total++; if (n8 !== 1) $display("FAIL rh_once got %0d exp 1", n8); else n_pass++;
      n_total++; if (opc_q[b+3] !== 32'h8000_0200) $display("FAIL rh_next_out got %h exp 80000200", opc_q[b+3]); else n_pass++;
      n_total++; if (req_q[rb+3] !== 32'h8000_0200) $display("FAIL rh_next_req got %h exp 80000200", req_q[rb+3]); else n_pass++;
    end
  endtask

  task automatic test_flush_hold();
    int b;
    do_reset(1'b1, 1'b0, 0);
    b = opc_q.size();
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) $display("FAIL flush got %b/%b/%h exp 0/1/80000300", out_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    out_ready = 1'b1;
    wait_outs(b + 1, "flush_wait");
    if (opc_q.size() >= b + 1) begin
      n_total++; if (opc_q[b] !== 32'h8000_0300) $display("FAIL flush_first got %h exp 80000300", opc_q[b]); else n_pass++;
    end
  endtask

  task automatic test_redirect_req();
    int b, rb;
    do_reset(1'b0, 1'b1, 0);
    b  = opc_q.size();
    rb = req_q.size();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0402;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) $display("FAIL rq_keep got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC); else n_pass++;
    imem_req_ready = 1'b1;
    wait_outs(b + 1, "rq_wait");
    if (opc_q.size() >= b + 1) begin
      n_total++; if (opc_q[b] !== 32'h8000_0400) $display("FAIL rq_first got %h exp 80000400", opc_q[b]); else n_pass++;
      n_total++; if (req_q[rb+1] !== 32'h8000_0400) $display("FAIL rq_refetch got %h exp 80000400", req_q[rb+1]); else n_pass++;
    end
  endtask

  task automatic test_fault();
    int b;
    err_addr = 32'h8000_0010;
    do_reset(1'b1, 1'b1, 0);
    b = opc_q.size();
    wait_outs(b + 6, "fault_wait");
    if (opc_q.size() >= b + 6) begin
      n_total++; if (oerr_q[b+3] !== 1'b0) $display("FAIL fault_before got %b exp 0", oerr_q[b+3]); else n_pass++;
      n_total++; if (oerr_q[b+4] !== 1'b1 || opc_q[b+4] !== 32'h8000_0010) $display("FAIL fault_flag got %b/%h exp 1/80000010", oerr_q[b+4], opc_q[b+4]); else n_pass++;
      n_total++; if (oerr_q[b+5] !== 1'b0 || opc_q[b+5] !== 32'h8000_0014) $display("FAIL fault_next got %b/%h exp 0/80000014", oerr_q[b+5], opc_q[b+5]); else n_pass++;
    end
    err_addr = 32'h0000_0001;
  endtask

  task automatic test_reset_mid();
    int b, rb;
    do_reset(1'b1, 1'b1, 3);
    wait_outs(opc_q.size() + 1, "rm_first");
    for (int i = 0; i < 20 && imem_rsp_ready !== 1'b1; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL rm_strobes got %b/%b/%b exp 0/0/0", imem_req_valid, imem_rsp_ready, out_valid); else n_pass++;
    n_total++; if (imem_req_addr !== RST_PC) $display("FAIL rm_addr got %h exp %h", imem_req_addr, RST_PC); else n_pass++;
    n_total++; if ({out_inst, out_pc, out_err} !== 65'd0) $display("FAIL rm_out_regs got %h/%h/%b exp 0", out_inst, out_pc, out_err); else n_pass++;
    repeat (3) @(negedge clk);
    mem_lat = 0;
    b  = opc_q.size();
    rb = req_q.size();
    rst = 1'b1;
    wait_outs(b + 1, "rm_after");
    if (opc_q.size() >= b + 1) begin
      n_total++; if (req_q[rb] !== RST_PC) $display("FAIL rm_first_req got %h exp %h", req_q[rb], RST_PC); else n_pass++;
      n_total++; if (opc_q[b] !== RST_PC) $display("FAIL rm_first_out got %h exp %h", opc_q[b], RST_PC); else n_pass++;
    end
  endtask

  initial begin
    err_addr = 32'h0000_0001;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold_ready();
    test_flush_hold();
    test_redirect_req();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
